// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Request/status bundle between a command source and the PS/2 host
// transmitter.
//   tx_valid   : source asks to send tx_data
//   tx_data    : command byte
//   tx_ready   : transmitter idle, a request this cycle is accepted
//   busy       : transfer in progress
//   done       : one-cycle end-of-transfer pulse
//   result     : valid with done (00 acked, 01 no ack, 10 timeout)
//   rx_inhibit : tells the receive path to ignore pad activity
// Handshake: a request is taken on a rising clk edge where tx_valid and
// tx_ready are both 1; tx_data is captured on that same edge. tx_valid seen
// while tx_ready is 0 has no effect.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic [1:0] result;
  logic       rx_inhibit;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, result, rx_inhibit
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, result, rx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte per request:
// inhibit (clock low), request-to-send (clock and data low), release the
// clock, shift out data/parity/stop on device clock falls, sample the ack,
// wait for the bus to go idle, then report the result.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   bus (slave)           : request/status bundle, see ps2_host_tx_if
//   ps2_clk_i, ps2_dat_i  : raw pad levels (asynchronous)
//   ps2_clk_oe, ps2_dat_oe: 1 pulls the pad low, 0 releases it
//   fsm_state             : current state encoding, for observation
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 430000,
  parameter int FILTER_LEN     = 8
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_i,
  input  logic           ps2_dat_i,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe,
  output logic [2:0]     fsm_state
);

  localparam int PMAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW   = $clog2(FILTER_LEN + 1);

  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, dat_f;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] phase_cnt;
  logic [WW-1:0] wd;
  logic          fall;
  logic          wait_ok;
  logic          wd_active;

  // The filtered clock drops on this edge: it is 1, the synchronized sample
  // is 0 and this is the last of the required run of differing samples.
  assign fall      = clk_f & ~clk_s2 & (clk_cnt == FLT_LAST);
  assign wait_ok   = (state == S_WAIT_IDLE) && clk_f && dat_f;
  assign wd_active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);

  assign bus.rx_inhibit = bus.busy;
  assign fsm_state      = state;

  // Pad synchronizers and glitch filters. The idle bus is high, so
  // everything resets to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      dat_f   <= 1'b1;
      clk_cnt <= '0;
      dat_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_i;
      dat_s2 <= dat_s1;
      if (clk_s2 != clk_f) begin
        if (clk_cnt == FLT_LAST) begin
          clk_f   <= clk_s2;
          clk_cnt <= '0;
        end else begin
          clk_cnt <= clk_cnt + FW'(1);
        end
      end else begin
        clk_cnt <= '0;
      end
      if (dat_s2 != dat_f) begin
        if (dat_cnt == FLT_LAST) begin
          dat_f   <= dat_s2;
          dat_cnt <= '0;
        end else begin
          dat_cnt <= dat_cnt + FW'(1);
        end
      end else begin
        dat_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= 2'b00;
      ps2_clk_oe   <= 1'b0;
      ps2_dat_oe   <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      phase_cnt    <= '0;
      wd           <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.tx_valid && bus.tx_ready) begin
            shift        <= {1'b1, ~^bus.tx_data, bus.tx_data};
            bus.busy     <= 1'b1;
            bus.tx_ready <= 1'b0;
            ps2_clk_oe   <= 1'b1;
            phase_cnt    <= '0;
            state        <= S_INHIBIT;
          end else begin
            // Also where tx_ready comes back one cycle after done.
            bus.tx_ready <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (phase_cnt == INH_LAST) begin
            phase_cnt  <= '0;
            ps2_dat_oe <= 1'b1;   // start bit
            state      <= S_REQ;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        S_REQ: begin
          if (phase_cnt == REQ_LAST) begin
            phase_cnt  <= '0;
            ps2_clk_oe <= 1'b0;   // hand the clock to the device
            bit_cnt    <= '0;
            state      <= S_SEND;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        S_SEND: begin
          if (fall) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= {1'b1, shift[9:1]};
            bit_cnt    <= bit_cnt + 4'd1;
            // The tenth fall puts the stop bit (released data) on the line.
            if (bit_cnt == 4'd9) state <= S_ACK;
          end
        end
        S_ACK: begin
          if (fall) begin
            bus.result <= dat_f ? 2'b01 : 2'b00;
            state      <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (wait_ok) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog: a fall always wins over expiry. Expiry overrides the
      // state updates above (later non-blocking assignment).
      if (state == S_REQ) begin
        wd <= '0;
      end else if (wd_active) begin
        if (fall || wait_ok) begin
          wd <= '0;
        end else if (wd == WD_LAST) begin
          wd         <= '0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          bus.done   <= 1'b1;
          bus.result <= 2'b10;
          bus.busy   <= 1'b0;
          state      <= S_IDLE;
        end else begin
          wd <= wd + WW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx with a PS/2 device model on open-drain pads.
// A timeline model predicts the pad enables and status outputs cycle by
// cycle from the request time; a result queue holds the expected outcome
// of each transfer; device-sampled frames are checked against literals and
// against a frame-building function.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH   = 50;
  localparam int REQ   = 16;
  localparam int TMO   = 5000;
  localparam int FLT   = 2;
  localparam int REL_T = 1 + INH + REQ;  // negedge index where the clock is first released
  localparam int HALF  = 20;             // device clock half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic [2:0] fsm_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  ps2_host_tx_if bus ();

  // Open-drain pads with pull-ups.
  assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // ---------------- timeline model + compare ----------------
  bit m_active   = 1'b0;
  int m_t        = 0;
  bit reset_seen = 1'b0;

  always @(negedge clk) begin
    logic [1:0] e;
    chk("rx_inhibit_eq_busy", bus.rx_inhibit, bus.busy);
    if (reset_seen) begin
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (bus.done) begin
        done_cnt++;
        chk("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("done_result", bus.result, e);
          if (e == 2'b10) chk("timeout_time", m_t, REL_T + TMO);
        end
        chk("done_busy", bus.busy, 0);
        chk("done_tx_ready", bus.tx_ready, 0);
        chk("done_clk_oe", ps2_clk_oe, 0);
        chk("done_dat_oe", ps2_dat_oe, 0);
        m_active = 1'b0;
      end else begin
        chk("act_busy", bus.busy, 1);
        chk("act_tx_ready", bus.tx_ready, 0);
        if (m_t <= INH) begin
          chk("inh_clk_oe", ps2_clk_oe, 1);
          chk("inh_dat_oe", ps2_dat_oe, 0);
        end else if (m_t <= INH + REQ) begin
          chk("req_clk_oe", ps2_clk_oe, 1);
          chk("req_dat_oe", ps2_dat_oe, 1);
        end else begin
          chk("send_clk_oe", ps2_clk_oe, 0);
          if (m_t == REL_T) chk("start_bit_dat_oe", ps2_dat_oe, 1);
          if (exp_q.size() != 0 && exp_q[0] == 2'b10 && m_t == REL_T + TMO)
            chk("timeout_done_missing", bus.done, 1);
        end
      end
    end else begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_tx_ready", bus.tx_ready, 1);
      chk("idle_clk_oe", ps2_clk_oe, 0);
      chk("idle_dat_oe", ps2_dat_oe, 0);
    end
    if (!reset && !m_active && bus.tx_valid && bus.tx_ready) begin
      m_active = 1'b1;
      m_t      = 0;
    end
    reset_seen = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    cyc(1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
  endtask

  task automatic wait_accept_drop();
    bit got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_seen", got, 1);
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  // PS/2 device: waits for the clock to be released after inhibit, samples
  // the start bit, then generates 10 clocks sampling data before each rise,
  // and an 11th clock with data held low when acking.
  task automatic dev_rx(input bit ack, input bit glitch, input int abort_fall,
                        output logic [10:0] frame);
    int n;
    frame = '0;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("dev_saw_inhibit", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    chk("dev_saw_release", ps2_clk_oe, 0);
    cyc(10);
    frame[0] = ps2_dat_i;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      if (k == abort_fall) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        cyc(HALF);
        return;
      end
      frame[k] = ps2_dat_i;
      dev_clk_low = 1'b0;
      if (glitch && k == 4) begin
        cyc(8);
        dev_clk_low = 1'b1;
        cyc(1);
        dev_clk_low = 1'b0;
        cyc(HALF - 9);
      end else begin
        cyc(HALF);
      end
    end
    dev_dat_low = ack;
    cyc(5);
    dev_clk_low = 1'b1;
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(5);
    dev_dat_low = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [10:0] fr, fr2;
    int          saved_done;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    reset        = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(5);

    // 0xED acked: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1 -> 11'h7DA
    exp_q.push_back(2'b00);
    start_tx(8'hED);
    fork
      wait_accept_drop();
      dev_rx(1'b1, 1'b0, 0, fr);
    join
    chk("ed_frame", fr, 11'h7DA);
    chk("ed_frame_model", fr, frame_of(8'hED));
    wait_done(200);
    @(negedge clk);
    chk("ready_after_done", bus.tx_ready, 1);
    cyc(10);

    // 0xF4 not acked: parity 0 -> {1,0,F4,0} = 11'h5E8
    exp_q.push_back(2'b01);
    start_tx(8'hF4);
    fork
      wait_accept_drop();
      dev_rx(1'b0, 1'b0, 0, fr);
    join
    chk("f4_frame", fr, 11'h5E8);
    chk("f4_parity", fr[9], 0);
    wait_done(200);
    cyc(10);

    // Device never clocks: timeout
    exp_q.push_back(2'b10);
    start_tx(8'h55);
    wait_accept_drop();
    wait_done(REL_T + TMO + 100);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_dat_oe", ps2_dat_oe, 0);
    cyc(10);

    // tx_valid held high, tx_data changed mid-frame
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    start_tx(8'h12);
    fork
      dev_rx(1'b1, 1'b0, 0, fr);
      begin cyc(200); bus.tx_data = 8'h34; end
    join
    chk("held_first_frame", fr, frame_of(8'h12));
    wait_done(200);
    fork
      wait_accept_drop();
      dev_rx(1'b1, 1'b0, 0, fr2);
    join
    chk("held_second_frame", fr2, frame_of(8'h34));
    wait_done(200);
    cyc(10);

    // Reset at fall 5, then 0x00 -> {1,1,00,0} = 11'h600
    saved_done = done_cnt;
    start_tx(8'h3C);
    fork
      wait_accept_drop();
      dev_rx(1'b1, 1'b0, 5, fr);
    join
    cyc(50);
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_done", done_cnt, saved_done);
    exp_q.push_back(2'b00);
    start_tx(8'h00);
    fork
      wait_accept_drop();
      dev_rx(1'b1, 1'b0, 0, fr);
    join
    chk("zero_frame", fr, 11'h600);
    wait_done(200);
    cyc(10);

    // One-cycle clock glitch during SEND
    exp_q.push_back(2'b00);
    start_tx(8'hA5);
    fork
      wait_accept_drop();
      dev_rx(1'b1, 1'b1, 0, fr);
    join
    chk("glitch_frame", fr, frame_of(8'hA5));
    wait_done(200);
    cyc(10);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the keyboard/mouse ports. It carries the opposite direction to the existing device-to-host PS/2 receive path.
- Sends one command byte per request, for example LED set (0xED) or mouse enable (0xF4). It performs the full inhibit, request-to-send, clocked-out frame and acknowledge sequence, then reports the result.
- Drives the open-drain clock and data pads through output-enables. A pad is pulled low when its enable is 1, and released (pulled up) when 0.
- While active it asserts rx_inhibit so the receive path ignores the frame.

Parameters:
- INHIBIT_CYCLES, 3000, number of clk cycles the clock line is held low before the request (≥100 µs at 28.636 MHz).
- REQ_CYCLES, 16, number of cycles data and clock are both held low before the clock is released.
- TIMEOUT_CYCLES, 430000, watchdog limit in cycles with no filtered clock falling edge (about 15 ms).
- FILTER_LEN, 8, number of consecutive identical synchronized samples needed to accept a pad level change.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  block is idle and can accept a request.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer ends.
- result  out  2  valid while done=1: 00 acked, 01 no ack, 10 timeout.
- rx_inhibit  out  1  equals busy; tells the receiver to ignore pad activity.
- ps2_clk_i  in  1  raw clock pad level (asynchronous).
- ps2_dat_i  in  1  raw data pad level (asynchronous).
- ps2_clk_oe  out  1  1 pulls the clock pad low.
- ps2_dat_oe  out  1  1 pulls the data pad low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values:
  - tx_ready=1.
  - busy=0, done=0, result=00.
  - ps2_clk_oe=0, ps2_dat_oe=0.
  - Filtered clock and data levels reset to 1.
  - All counters reset to 0.
  - A reset mid-transfer releases both pads on the next edge and returns to IDLE with no done pulse.
- Input filtering:
  - Each pad passes through a 2-flop synchronizer.
  - The filtered level changes only after FILTER_LEN consecutive equal synchronized samples.
  - fall = filtered clock level going 1→0.
- Frame content:
  - shift register = {1'b1 stop, parity, tx_data}, bit 0 sent first.
  - parity = ~^tx_data (odd parity).
- State machine (state, what it does, exit condition):
  - IDLE: tx_ready=1.
    - tx_valid && tx_ready latches tx_data and moves to INHIBIT.
    - Next cycle: busy=1, ps2_clk_oe=1.
    - tx_valid while busy is ignored.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: ps2_clk_oe=1 and ps2_dat_oe=1 (start bit 0) for REQ_CYCLES cycles, then go to SEND.
    - On leaving REQ: ps2_clk_oe=0, bit counter=0, watchdog cleared.
  - SEND: on each fall, ps2_dat_oe = ~shift[0], then shift right and increment the bit counter.
    - Falls 1–8 present data bits 0–7.
    - Fall 9 presents parity.
    - Fall 10 releases data (stop bit, ps2_dat_oe=0).
    - After fall 10, go to ACK.
  - ACK: on the next fall, sample filtered data. 0 means acked (result 00); 1 means no ack (result 01). Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and filtered data=1, then pulse done with the stored result, clear busy and go to IDLE.
    - tx_ready returns to 1 on the cycle after done.
- Watchdog:
  - Counts in SEND, ACK and WAIT_IDLE, and clears on each fall.
  - Reaching TIMEOUT_CYCLES releases both pads, pulses done with result=10, and returns to IDLE in the same cycle.
- Simultaneous events: if fall and watchdog expiry occur in the same cycle, fall wins and the watchdog clears.
- The device pulling the clock low during INHIBIT or REQ has no effect (the host owns the lines then).
- Latency: from request to the first released clock is 1+INHIBIT_CYCLES+REQ_CYCLES cycles.

Test Plan:
- Setup: sim device model with INHIBIT_CYCLES=50, TIMEOUT_CYCLES=5000, FILTER_LEN=2.
- Send 0xED, device acks:
  - ps2_clk_oe high for 50 cycles, then data and clock both low for 16 cycles.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - done pulses once with result=00; tx_ready returns to 1.
- Send 0xF4 with device not acking (data left high on fall 11): parity bit observed is 0; done pulses with result=01.
- Device never clocks after REQ: exactly 5000 cycles after clock release, done pulses with result=10 and both oe are 0.
- tx_valid held high across a transfer with tx_data changed mid-frame: the first byte is sent unchanged; the second request is accepted only after tx_ready=1.
- reset asserted at fall 5: the next cycle both oe are 0, busy=0, and no done pulse occurs; a following request for 0x00 (parity 1) completes with result=00.
- 1-cycle glitch on ps2_clk_i during SEND: no bit advance occurs; the frame is still received correctly.
